// File: rtl/midi_pkg.sv
// Shared MIDI transmit definitions: FSM states, status class constants and
// the status-byte to data-byte-count rule.
package midi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND_CMD,
      SEND_D0,
      SEND_D1,
      DONE
   } tx_state_t;

   localparam logic [7:0] ST_NOTE_OFF   = 8'h80;
   localparam logic [7:0] ST_PROG_CHG   = 8'hC0;
   localparam logic [7:0] ST_CHAN_PRESS = 8'hD0;
   localparam logic [7:0] ST_SYSTEM     = 8'hF0;
   localparam logic [7:0] ST_REALTIME   = 8'hF8;

   // Channel voice/mode statuses 0x80..0xEF; the only ones running status applies to.
   function automatic logic is_channel(input logic [7:0] status);
      return (status >= ST_NOTE_OFF) && (status < ST_SYSTEM);
   endfunction

   function automatic logic [1:0] data_count(input logic [7:0] status);
      logic [1:0] n;
      n = 2'd2;
      if (status >= ST_SYSTEM) begin
         if (status == 8'hF2)
            n = 2'd2;
         else if ((status == 8'hF1) || (status == 8'hF3))
            n = 2'd1;
         else
            n = 2'd0;
      end else if ((status[7:4] == ST_PROG_CHG[7:4]) ||
                   (status[7:4] == ST_CHAN_PRESS[7:4])) begin
         n = 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/single_midi_out.sv
// Bit-level 8N1 serialiser: start bit, BYTE_W data bits LSB first, stop bit,
// each bit held for exactly BAUD_DIV clocks. Line idles high.
module single_midi_out #(
   parameter int unsigned BYTE_W   = 8,
   parameter int unsigned BAUD_DIV = 1536
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              byte_done,
   output logic              MIDI_OUT
);

   localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
   localparam int unsigned LAST_BIT = BYTE_W + 1;

   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_idx;
   logic [BYTE_W:0]  shreg;

   // byte_ready doubles as the idle flag; the start bit is driven on the accept edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '1;
         byte_ready <= 1'b1;
         byte_done  <= 1'b0;
         MIDI_OUT   <= 1'b1;
      end else begin
         byte_done <= 1'b0;
         if (byte_ready) begin
            if (byte_valid) begin
               byte_ready <= 1'b0;
               MIDI_OUT   <= 1'b0;
               shreg      <= {1'b1, byte_in};
               baud_cnt   <= '0;
               bit_idx    <= '0;
            end
         end else if (baud_cnt == CNT_W'(BAUD_DIV - 1)) begin
            baud_cnt <= '0;
            if (bit_idx == 4'(LAST_BIT)) begin
               byte_ready <= 1'b1;
               byte_done  <= 1'b1;
               MIDI_OUT   <= 1'b1;
            end else begin
               bit_idx  <= bit_idx + 4'd1;
               MIDI_OUT <= shreg[0];
               shreg    <= {1'b1, shreg[BYTE_W:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/midi_message_tx.sv
// MIDI message transmitter: one status + 0..2 data bytes per handshake, sent as 8N1.
// Build option MIDI_TX_RUNNING_STATUS_EN omits a channel status equal to last_status.
module midi_message_tx
   import midi_pkg::*;
#(
   parameter int unsigned BYTE_W    = 8,
   parameter int unsigned MIDI_BAUD = 31250,
   parameter int unsigned SYSCLK_F  = 48000000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              MSG_VALID,
   output logic              MSG_READY,
   input  logic [BYTE_W-1:0] MIDI_CMD,
   input  logic [BYTE_W-1:0] MIDI_DAT_0,
   input  logic [BYTE_W-1:0] MIDI_DAT_1,
   output logic              MIDI_OUT,
   output logic              TX_BUSY,
   output logic              MSG_DONE,
   output logic              MSG_ERR
);

   localparam int unsigned BAUD_DIV = SYSCLK_F / MIDI_BAUD;

`ifdef MIDI_TX_RUNNING_STATUS_EN
   localparam bit RS_EN = 1'b1;
`else
   localparam bit RS_EN = 1'b0;
`endif

   tx_state_t         state;
   logic [BYTE_W-1:0] cmd_q;
   logic [BYTE_W-1:0] d0_q;
   logic [BYTE_W-1:0] d1_q;
   logic [1:0]        cnt_q;
   logic              rs_skip;
   logic [BYTE_W-1:0] last_status;
   logic [BYTE_W-1:0] tx_byte;
   logic              tx_valid;
   logic              byte_ready;
   logic              byte_done;

   single_midi_out #(
      .BYTE_W   (BYTE_W),
      .BAUD_DIV (BAUD_DIV)
   ) u_ser (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .byte_in    (tx_byte),
      .byte_valid (tx_valid),
      .byte_ready (byte_ready),
      .byte_done  (byte_done),
      .MIDI_OUT   (MIDI_OUT)
   );

   // Message sequencer; each SEND_* issues one byte and waits for its byte_done.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         cmd_q       <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         cnt_q       <= '0;
         rs_skip     <= 1'b0;
         last_status <= '0;
         tx_byte     <= '0;
         tx_valid    <= 1'b0;
         MSG_READY   <= 1'b0;
         TX_BUSY     <= 1'b0;
         MSG_DONE    <= 1'b0;
         MSG_ERR     <= 1'b0;
      end else begin
         MSG_DONE <= 1'b0;
         MSG_ERR  <= 1'b0;
         if (tx_valid && byte_ready)
            tx_valid <= 1'b0;

         case (state)
            IDLE: begin
               MSG_READY <= 1'b1;
               if (MSG_VALID && MSG_READY) begin
                  if (MIDI_CMD[BYTE_W-1]) begin
                     state     <= LOAD;
                     MSG_READY <= 1'b0;
                     TX_BUSY   <= 1'b1;
                     cmd_q     <= MIDI_CMD;
                     d0_q      <= {1'b0, MIDI_DAT_0[BYTE_W-2:0]};
                     d1_q      <= {1'b0, MIDI_DAT_1[BYTE_W-2:0]};
                     cnt_q     <= data_count(8'(MIDI_CMD));
                     // Compare against the pre-update value: the decision belongs to this message.
                     rs_skip   <= RS_EN && is_channel(8'(MIDI_CMD)) &&
                                  (MIDI_CMD == last_status);
                     if (is_channel(8'(MIDI_CMD)))
                        last_status <= MIDI_CMD;
                     else if (8'(MIDI_CMD) < ST_REALTIME)
                        last_status <= '0;
                  end else begin
                     MSG_ERR <= 1'b1;
                  end
               end
            end

            LOAD: begin
               tx_valid <= 1'b1;
               if (rs_skip) begin
                  tx_byte <= d0_q;
                  state   <= SEND_D0;
               end else begin
                  tx_byte <= cmd_q;
                  state   <= SEND_CMD;
               end
            end

            SEND_CMD: begin
               if (byte_done) begin
                  if (cnt_q != 2'd0) begin
                     tx_byte  <= d0_q;
                     tx_valid <= 1'b1;
                     state    <= SEND_D0;
                  end else begin
                     MSG_DONE <= 1'b1;
                     state    <= DONE;
                  end
               end
            end

            SEND_D0: begin
               if (byte_done) begin
                  if (cnt_q == 2'd2) begin
                     tx_byte  <= d1_q;
                     tx_valid <= 1'b1;
                     state    <= SEND_D1;
                  end else begin
                     MSG_DONE <= 1'b1;
                     state    <= DONE;
                  end
               end
            end

            SEND_D1: begin
               if (byte_done) begin
                  MSG_DONE <= 1'b1;
                  state    <= DONE;
               end
            end

            DONE: begin
               TX_BUSY   <= 1'b0;
               MSG_READY <= 1'b1;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
